// File: rtl/oclib_drp_arbiter.sv
// Round-robin arbiter sharing one DRP slave port between several DRP masters.
// Requests are latched, granted one at a time, and the response is routed back.
package oclib_pkg;
    typedef struct packed {
        logic        enable;
        logic        write;
        logic [15:0] address;
        logic [15:0] wdata;
    } drp_s;

    typedef struct packed {
        logic        ready;
        logic [15:0] rdata;
    } drp_fb_s;
endpackage

module oclib_drp_arbiter #(
    parameter int  Requesters    = 2,
    parameter int  TimeoutCycles = 1024,
    parameter type DrpType       = oclib_pkg::drp_s,
    parameter type DrpFbType     = oclib_pkg::drp_fb_s
) (
    input  logic     clock,
    input  logic     resetN,
    input  DrpType   drpIn   [Requesters],
    output DrpFbType drpInFb [Requesters],
    output DrpType   drp,
    input  DrpFbType drpFb,
    output logic     timeoutError
);
    localparam int IdxW = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Requesters - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e                state;
    state_e                stateNext;
    logic [Requesters-1:0] pending;
    DrpType                latched [Requesters];
    logic [IdxW-1:0]       lastGrant;
    logic [IdxW-1:0]       grant;
    logic [IdxW-1:0]       pick;
    logic [IdxW-1:0]       cand;
    logic                  pickValid;
    logic [CntW-1:0]       count;
    logic                  doGrant;
    logic                  doComplete;
    logic                  doTimeout;

    // Nearest pending requester after lastGrant wins; descending scan lets the closest overwrite.
    always_comb begin
        pick      = lastGrant;
        pickValid = 1'b0;
        cand      = '0;
        for (int off = Requesters; off >= 1; off--) begin
            cand = IdxW'((int'(lastGrant) + off) % Requesters);
            if (pending[cand]) begin
                pick      = cand;
                pickValid = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        doGrant    = 1'b0;
        doComplete = 1'b0;
        doTimeout  = 1'b0;
        case (state)
            StIdle: begin
                if (pickValid) begin
                    doGrant   = 1'b1;
                    stateNext = StWait;
                end
            end
            StWait: begin
                if (drpFb.ready) begin
                    doComplete = 1'b1;
                    stateNext  = StIdle;
                end else if ((TimeoutCycles != 0) && (count == CntLast)) begin
                    doTimeout = 1'b1;
                    stateNext = StIdle;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pending      <= '0;
            lastGrant    <= LastIdx;
            grant        <= '0;
            count        <= '0;
            drp          <= '0;
            timeoutError <= 1'b0;
            for (int i = 0; i < Requesters; i++) begin
                drpInFb[i] <= '0;
                latched[i] <= '0;
            end
        end else begin
            drp.enable <= 1'b0;
            drp.write  <= 1'b0;
            // A repeat enable while still pending is dropped so the latched request is never overwritten.
            for (int i = 0; i < Requesters; i++) begin
                drpInFb[i].ready <= 1'b0;
                if (drpIn[i].enable && !pending[i]) begin
                    pending[i] <= 1'b1;
                    latched[i] <= drpIn[i];
                end
            end
            if (doGrant) begin
                drp        <= latched[pick];
                drp.enable <= 1'b1;
                grant      <= pick;
                count      <= '0;
            end else if (state == StWait) begin
                count <= count + 1'b1;
            end
            if (doComplete || doTimeout) begin
                pending[grant]       <= 1'b0;
                lastGrant            <= grant;
                drpInFb[grant].ready <= 1'b1;
                drpInFb[grant].rdata <= doTimeout ? '1 : (latched[grant].write ? '0 : drpFb.rdata);
            end
            if (doTimeout) begin
                timeoutError <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_oclib_drp_arbiter.sv
// Directed and randomized checks of the DRP arbiter against a transaction-level model.
module tb_oclib_drp_arbiter;
    import oclib_pkg::*;

    localparam int NReq = 2;
    localparam int Tmo  = 16;

    logic    clock  = 1'b0;
    logic    resetN = 1'b1;
    drp_s    drpIn   [NReq];
    drp_fb_s drpInFb [NReq];
    drp_s    drp;
    drp_fb_s drpFb;
    logic    timeoutError;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Requester-side model: 0 idle, 1 waiting for grant, 2 granted
    int          reqState    [NReq];
    int          issueCyc    [NReq];
    int          reissueFrom [NReq];
    logic        reqWrite    [NReq];
    logic [15:0] reqAddr     [NReq];
    logic [15:0] reqData     [NReq];
    logic [15:0] modelRdata  [NReq];
    logic        modelTmo;

    bit          wantReq   [NReq];
    logic        wantWrite [NReq];
    logic [15:0] wantAddr  [NReq];
    logic [15:0] wantData  [NReq];

    bit          busy;
    int          grantReq;
    int          completeAt;
    bit          completeBySlave;
    logic [15:0] completeData;
    int          readyAt;
    int          readyReq;
    bit          readyTimeout;
    logic [15:0] readyData;
    int          lastModel;
    int          freeFrom;

    bit          randomMode = 1'b0;
    int          fixedLat   = 0;
    bit          slaveMute  = 1'b0;
    bit          spurious   = 1'b0;
    logic [15:0] slaveDataQ [$];
    logic [15:0] obsAddrLog [$];
    int          obsCycLog  [$];

    always #5 clock = ~clock;

    oclib_drp_arbiter #(
        .Requesters   (NReq),
        .TimeoutCycles(Tmo)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .drpIn       (drpIn),
        .drpInFb     (drpInFb),
        .drp         (drp),
        .drpFb       (drpFb),
        .timeoutError(timeoutError)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < NReq; i++) begin
            reqState[i]    = 0;
            reissueFrom[i] = 0;
            issueCyc[i]    = 0;
            modelRdata[i]  = 16'h0;
            wantReq[i]     = 1'b0;
        end
        modelTmo  = 1'b0;
        busy      = 1'b0;
        readyAt   = -1;
        lastModel = NReq - 1;
        freeFrom  = 0;
        spurious  = 1'b0;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        for (int i = 0; i < NReq; i++) drpIn[i] = '0;
        drpFb = '0;
        #1;
        for (int i = 0; i < NReq; i++) begin
            checkOutput($sformatf("rstReady%0d", i), 32'(drpInFb[i].ready), 32'd0);
            checkOutput($sformatf("rstRdata%0d", i), 32'(drpInFb[i].rdata), 32'd0);
        end
        checkOutput("rstDrpEnable", 32'(drp.enable), 32'd0);
        checkOutput("rstDrpWrite", 32'(drp.write), 32'd0);
        checkOutput("rstDrpAddress", 32'(drp.address), 32'd0);
        checkOutput("rstDrpWdata", 32'(drp.wdata), 32'd0);
        checkOutput("rstTimeoutError", 32'(timeoutError), 32'd0);
        resetModel();
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
    endtask

    // One clock: check outputs of this cycle against the model, then drive this cycle's inputs.
    task automatic applyStimulus();
        int          expGrant;
        bit          expReady;
        int          lat;
        int          idx;
        int          tmoAt;
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NReq; i++) begin
            expReady = (readyAt == cyc) && (readyReq == i);
            if (expReady) begin
                modelRdata[i]  = readyData;
                reqState[i]    = 0;
                reissueFrom[i] = cyc + 1;
            end
            checkOutput($sformatf("ready%0d", i), 32'(drpInFb[i].ready), 32'(expReady));
            checkOutput($sformatf("rdata%0d", i), 32'(drpInFb[i].rdata), 32'(modelRdata[i]));
        end
        if (readyAt == cyc && readyTimeout) modelTmo = 1'b1;
        checkOutput("timeoutError", 32'(timeoutError), 32'(modelTmo));

        if (drp.enable === 1'b1) begin
            obsAddrLog.push_back(drp.address);
            obsCycLog.push_back(cyc);
        end

        // Requests become visible to arbitration one cycle after capture; grant shows one cycle later.
        expGrant = -1;
        if (!busy && cyc >= freeFrom) begin
            for (int off = 1; off <= NReq && expGrant < 0; off++) begin
                idx = (lastModel + off) % NReq;
                if (reqState[idx] == 1 && issueCyc[idx] <= cyc - 2) expGrant = idx;
            end
        end
        checkOutput("drpEnable", 32'(drp.enable), 32'(expGrant >= 0));
        if (expGrant >= 0) begin
            checkOutput("drpWrite", 32'(drp.write), 32'(reqWrite[expGrant]));
            checkOutput("drpAddress", 32'(drp.address), 32'(reqAddr[expGrant]));
            checkOutput("drpWdata", 32'(drp.wdata), 32'(reqData[expGrant]));
            busy               = 1'b1;
            grantReq           = expGrant;
            reqState[expGrant] = 2;
            lat   = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 5));
            tmoAt = cyc + Tmo - 1;
            if (!slaveMute && (cyc + lat) <= tmoAt) begin
                completeAt      = cyc + lat;
                completeBySlave = 1'b1;
                completeData    = (slaveDataQ.size() > 0) ? slaveDataQ.pop_front() : 16'($urandom);
            end else begin
                completeAt      = tmoAt;
                completeBySlave = 1'b0;
            end
        end else begin
            checkOutput("drpWriteIdle", 32'(drp.write), 32'd0);
        end

        drpFb = '0;
        if (busy && cyc == completeAt) begin
            if (completeBySlave) begin
                drpFb.ready = 1'b1;
                drpFb.rdata = completeData;
            end
            readyAt      = cyc + 1;
            readyReq     = grantReq;
            readyTimeout = !completeBySlave;
            readyData    = !completeBySlave ? 16'hFFFF : (reqWrite[grantReq] ? 16'h0000 : completeData);
            busy         = 1'b0;
            freeFrom     = cyc + 2;
            lastModel    = grantReq;
        end else if (spurious && !busy) begin
            drpFb.ready = 1'b1;
            drpFb.rdata = 16'($urandom);
            spurious    = 1'b0;
        end

        for (int i = 0; i < NReq; i++) begin
            drpIn[i] = '0;
            if (reqState[i] != 0) begin
                if (randomMode && $urandom_range(0, 7) == 0) begin
                    drpIn[i].enable  = 1'b1;
                    drpIn[i].write   = 1'($urandom);
                    drpIn[i].address = 16'($urandom);
                    drpIn[i].wdata   = 16'($urandom);
                end
            end else if (cyc >= reissueFrom[i]) begin
                if (randomMode && $urandom_range(0, 2) == 0) begin
                    wantReq[i]   = 1'b1;
                    wantWrite[i] = 1'($urandom);
                    wantAddr[i]  = 16'($urandom);
                    wantData[i]  = 16'($urandom);
                end
                if (wantReq[i]) begin
                    drpIn[i].enable  = 1'b1;
                    drpIn[i].write   = wantWrite[i];
                    drpIn[i].address = wantAddr[i];
                    drpIn[i].wdata   = wantData[i];
                    reqState[i] = 1;
                    issueCyc[i] = cyc;
                    reqWrite[i] = wantWrite[i];
                    reqAddr[i]  = wantAddr[i];
                    reqData[i]  = wantData[i];
                    wantReq[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic setWant(input int i, input logic wr, input logic [15:0] addr, input logic [15:0] data);
        wantReq[i]   = 1'b1;
        wantWrite[i] = wr;
        wantAddr[i]  = addr;
        wantData[i]  = data;
    endtask

    initial begin
        for (int i = 0; i < NReq; i++) drpIn[i] = '0;
        drpFb = '0;
        resetModel();
        #2;
        doReset();

        // Round-robin from reset: requester 0 first
        fixedLat = 2;
        slaveDataQ.push_back(16'hAAAA);
        slaveDataQ.push_back(16'h5555);
        setWant(0, 1'b0, 16'h0001, 16'h1234);
        setWant(1, 1'b0, 16'h0002, 16'h5678);
        runCycles(14);
        checkOutput("rrFirstAddr", 32'(obsAddrLog[0]), 32'h0001);
        checkOutput("rrSecondAddr", 32'(obsAddrLog[1]), 32'h0002);
        checkOutput("rrRdata0", 32'(drpInFb[0].rdata), 32'hAAAA);
        checkOutput("rrRdata1", 32'(drpInFb[1].rdata), 32'h5555);

        // Single write from requester 0, slave answers 3 cycles after drp.enable
        fixedLat = 3;
        setWant(0, 1'b1, 16'h0012, 16'hBEEF);
        runCycles(10);
        checkOutput("writeAddr", 32'(obsAddrLog[2]), 32'h0012);
        checkOutput("writeRdata0", 32'(drpInFb[0].rdata), 32'h0000);

        // Both repeat after requester 0 was last served: requester 1 wins
        setWant(0, 1'b0, 16'h0003, 16'h0000);
        setWant(1, 1'b0, 16'h0004, 16'h0000);
        runCycles(14);
        checkOutput("repeatFirstAddr", 32'(obsAddrLog[3]), 32'h0004);
        checkOutput("repeatSecondAddr", 32'(obsAddrLog[4]), 32'h0003);

        // Timeout with a silent slave, then a late ready that must be ignored
        slaveMute = 1'b1;
        setWant(0, 1'b0, 16'h0020, 16'h0000);
        runCycles(22);
        slaveMute = 1'b0;
        checkOutput("timeoutAddr", 32'(obsAddrLog[5]), 32'h0020);
        checkOutput("timeoutRdata", 32'(drpInFb[0].rdata), 32'hFFFF);
        checkOutput("timeoutSticky", 32'(timeoutError), 32'd1);
        spurious = 1'b1;
        runCycles(4);
        checkOutput("timeoutStickyLate", 32'(timeoutError), 32'd1);

        // Reset while requester 1 is in flight; then a clean write from requester 1
        fixedLat = 12;
        setWant(1, 1'b0, 16'h0030, 16'h0000);
        runCycles(5);
        checkOutput("midOpAddr", 32'(obsAddrLog[6]), 32'h0030);
        doReset();
        runCycles(16);
        fixedLat = 3;
        setWant(1, 1'b1, 16'h0012, 16'hBEEF);
        runCycles(10);
        checkOutput("postRstAddr", 32'(obsAddrLog[7]), 32'h0012);

        // Back-to-back reads with zero slave latency: one grant every 4 cycles
        fixedLat = 0;
        slaveDataQ.push_back(16'h1111);
        slaveDataQ.push_back(16'h2222);
        slaveDataQ.push_back(16'h3333);
        slaveDataQ.push_back(16'h4444);
        for (int k = 0; k < 4; k++) begin
            setWant(0, 1'b0, 16'(16'h0040 + k), 16'h0000);
            runCycles(4);
        end
        for (int k = 8; k < 11; k++) begin
            checkOutput($sformatf("b2bSpacing%0d", k - 8), 32'(obsCycLog[k + 1] - obsCycLog[k]), 32'd4);
        end
        checkOutput("b2bLastRdata", 32'(drpInFb[0].rdata), 32'h4444);

        // Spurious slave ready while idle
        spurious = 1'b1;
        runCycles(4);

        // Randomized traffic, including illegal repeat pulses while pending
        fixedLat   = -1;
        randomMode = 1'b1;
        runCycles(400);
        randomMode = 1'b0;
        runCycles(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
